// File: rtl/mux_nx1_rr.sv
// N-to-1 registered mux with fixed-select or round-robin arbitration and a
// single-entry valid/ready output stage that sustains one word per cycle.
module mux_nx1_rr #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    localparam int SW   = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic                  mode,
    input  logic [SW-1:0]         sel,
    output logic [WIDTH-1:0]      out_data,
    output logic [SW-1:0]         out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [N_CH-1:0][WIDTH-1:0] words;
    logic [SW-1:0]              ptr;
    logic                       can_load;
    logic                       rr_found;
    logic [SW-1:0]              rr_idx;
    logic [SW:0]                idx_w;
    logic                       fx_ok;
    logic                       cand_ok;
    logic [SW-1:0]              cand_idx;
    logic                       grant;

    assign words    = in_data;
    assign can_load = !out_valid || out_ready;

    // Search ptr+1 .. ptr+N_CH (mod N_CH); ptr itself is visited last.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        idx_w    = '0;
        for (int k = 1; k <= N_CH; k++) begin
            idx_w = {1'b0, ptr} + (SW+1)'(k);
            if (idx_w >= (SW+1)'(N_CH))
                idx_w = idx_w - (SW+1)'(N_CH);
            if (!rr_found && in_valid[idx_w[SW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = idx_w[SW-1:0];
            end
        end
    end

    // Out-of-range select never grants, even when N_CH is not a power of 2.
    always_comb begin
        fx_ok = 1'b0;
        if ({1'b0, sel} < (SW+1)'(N_CH))
            fx_ok = in_valid[sel];
    end

    assign cand_ok  = mode ? rr_found : fx_ok;
    assign cand_idx = mode ? rr_idx : sel;
    assign grant    = !rst && can_load && cand_ok;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_CH; i++)
            in_ready[i] = grant && (cand_idx == SW'(i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SW'(N_CH - 1);
        end else if (grant) begin
            out_valid <= 1'b1;
            out_data  <= words[cand_idx];
            out_ch    <= cand_idx;
            if (mode)
                ptr <= cand_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/mux_nx1_rr.md
MUX_NX1_RR -- requirements
Module: mux_nx1_rr

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, giving the number of input channels (legal range 2..16).
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the data bits per channel.
REQ-003 The block SHALL define SW = clog2(N_CH) as the select and channel-index width.
REQ-004 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port in_data, input, N_CH*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port in_valid, input, N_CH: bit i set means channel i holds a word.
REQ-008 Port in_ready, output, N_CH: one-hot or zero; bit i set means channel i is accepted this cycle.
REQ-009 Port mode, input, 1: 0 selects fixed-select mode; 1 selects round-robin mode.
REQ-010 Port sel, input, SW: the channel index used in fixed-select mode.
REQ-011 Port out_data, output, WIDTH: the registered selected word.
REQ-012 Port out_ch, output, SW: the index of the channel that sourced out_data.
REQ-013 Port out_valid, output, 1: out_data and out_ch are valid.
REQ-014 Port out_ready, input, 1: the consumer accepts the word when out_valid and out_ready are both 1.

Function
REQ-015 The block SHALL grant at most one channel per cycle, and only when can_load = !out_valid || out_ready.
REQ-016 in_ready SHALL be purely combinational: the one-hot grant when can_load is 1 and a candidate exists, and all zeros otherwise.
REQ-017 In fixed-select mode, the candidate SHALL be sel when in_valid[sel] = 1 and sel < N_CH; otherwise there SHALL be no grant.
REQ-018 In round-robin mode, the candidate SHALL be the first i with in_valid[i] = 1, searching ptr+1, ptr+2, ... modulo N_CH and ending with ptr itself.
REQ-019 On a grant, the block SHALL load out_data = channel word, out_ch = index and out_valid = 1 at the next edge, giving 1-cycle latency.
REQ-020 On a round-robin grant, ptr SHALL update to the granted index; ptr SHALL be unchanged on fixed-select grants and on cycles with no grant.
REQ-021 When can_load is 1 and no candidate exists, out_valid SHALL clear to 0 at the next edge if out_ready = 1.
REQ-022 While out_valid = 1 and out_ready = 0, out_data, out_ch and out_valid SHALL hold stable, and in_ready SHALL be all zeros.
REQ-023 A simultaneous drain and load (out_valid = 1, out_ready = 1, candidate present) SHALL replace the output word with no bubble cycle, sustaining 1 word per cycle.
REQ-024 A mode or sel change SHALL take effect on the same-cycle grant decision; a word already held in the output register SHALL be unaffected.
REQ-025 Pointer wrap SHALL be modulo N_CH, so after granting N_CH-1 the search SHALL begin at channel 0; this SHALL hold for non-power-of-2 N_CH.

Reset
REQ-026 When rst = 1 at a clock edge, the block SHALL set out_valid = 0, out_data = 0, out_ch = 0 and ptr = N_CH-1, so that the first round-robin search begins at channel 0.
REQ-027 While rst = 1, in_ready SHALL be all zeros.
REQ-028 A reset asserted mid-stall SHALL discard the held word.

Verification (N_CH = 4, WIDTH = 8)
REQ-029 Reset check: assert rst, then release with out_ready = 1 -> out_valid = 0, out_data = 0x00, out_ch = 0; first round-robin grant goes to the lowest valid channel.
REQ-030 Fixed-select check: mode = 0, sel = 2, in_valid = 4'b1111, channel 2 word = 0xA5 -> in_ready = 4'b0100; next cycle out_data = 0xA5, out_ch = 2.
REQ-031 Round-robin fairness check: mode = 1, in_valid = 4'b1111, out_ready = 1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 with out_valid continuously 1.
REQ-032 Sparse/wrap check: mode = 1, ptr = 3, in_valid = 4'b1010 -> grant order 1, 3, 1.
REQ-033 Backpressure check: out_valid = 1, out_data = 0x3C, out_ready = 0 for 3 cycles -> in_ready = 0 and outputs stable; on out_ready = 1 the next word loads with no bubble.
REQ-034 Invalid select and reset mid-stall check: mode = 0, sel = 1, in_valid[1] = 0 -> no grant and out_valid drops after drain; rst during a stall -> out_valid = 0 on the next cycle.
